// File: rtl/mult_unit.sv
// -----------------------------------------------------------------------------
// mult_unit
//
// Iterative RV64M multiplier (MUL, MULH, MULHSU, MULHU, MULW). Accepts one
// sourced operation through a valid/ready handshake, retires BITS_PER_CYCLE
// multiplier bits per BUSY cycle, spends one FIX cycle on sign fix-up and
// result selection, then holds the tagged result in DONE until it is taken.
// One operation in flight at a time; flush kills it.
//
// Ports
//   clk        in   clock, rising edge
//   resetn     in   asynchronous active-low reset
//   in_data    in   packed sourced op, LSB first:
//                     [63:0]                      d1  (rs1)
//                     [127:64]                    d2  (rs2)
//                     [128 +: PREG_W]             dst (destination preg)
//                     [128+PREG_W +: PC_W]        pc
//                     [128+PREG_W+PC_W]           valid
//   in_op      in   000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 MULW,
//                   101..111 reserved (result 0)
//   in_ready   out  unit can accept this cycle
//   flush      in   kill any in-flight or pending operation
//   out_valid  out  result available
//   out_ready  in   consumer takes result
//   out_data   out  64-bit result
//   out_dst    out  destination physical register of the result
//   out_pc     out  PC of the producing instruction
// -----------------------------------------------------------------------------
module mult_unit #(
    parameter int unsigned BITS_PER_CYCLE = 4,
    parameter int unsigned PREG_W         = 7,
    parameter int unsigned PC_W           = 64
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [PC_W+PREG_W+128:0]       in_data,
    input  logic [2:0]                     in_op,
    output logic                           in_ready,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [63:0]                    out_data,
    output logic [PREG_W-1:0]              out_dst,
    output logic [PC_W-1:0]                out_pc
);

    localparam int unsigned N     = 64 / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIX,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_MULW   = 3'b100
    } op_t;

    // ------------------------------------------------------------------
    // Input field extraction
    // ------------------------------------------------------------------
    logic              in_valid;
    logic [63:0]       in_d1;
    logic [63:0]       in_d2;
    logic [PREG_W-1:0] in_dst;
    logic [PC_W-1:0]   in_pc;

    assign in_d1    = in_data[63:0];
    assign in_d2    = in_data[127:64];
    assign in_dst   = in_data[128 +: PREG_W];
    assign in_pc    = in_data[128+PREG_W +: PC_W];
    assign in_valid = in_data[128+PREG_W+PC_W];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_q,    state_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [127:0]      acc_q,      acc_d;
    logic [63:0]       mcand_q,    mcand_d;
    logic [63:0]       mplier_q,   mplier_d;
    logic              neg_q,      neg_d;
    logic [2:0]        op_q,       op_d;
    logic [PREG_W-1:0] dst_q,      dst_d;
    logic [PC_W-1:0]   pc_q,       pc_d;
    logic [63:0]       out_data_q, out_data_d;

    logic accept;

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state_q == S_DONE);
    assign out_data  = out_data_q;
    // dst/pc only change on accept, which always leaves DONE, so they are
    // stable for the whole time out_valid is high.
    assign out_dst   = dst_q;
    assign out_pc    = pc_q;

    // ------------------------------------------------------------------
    // Operand preparation: magnitudes and result sign
    // ------------------------------------------------------------------
    logic        rs1_signed;
    logic        rs2_signed;
    logic [63:0] opa;
    logic [63:0] opb;
    logic        sign_a;
    logic        sign_b;
    logic [63:0] mag_a;
    logic [63:0] mag_b;

    always_comb begin
        rs1_signed = (in_op == OP_MUL) || (in_op == OP_MULH) || (in_op == OP_MULHSU);
        rs2_signed = (in_op == OP_MUL) || (in_op == OP_MULH);
        opa        = in_d1;
        opb        = in_d2;
        if (in_op == OP_MULW) begin
            // Low 32 bits of a product do not depend on operand signedness.
            opa        = {32'b0, in_d1[31:0]};
            opb        = {32'b0, in_d2[31:0]};
            rs1_signed = 1'b0;
            rs2_signed = 1'b0;
        end
        sign_a = rs1_signed && opa[63];
        sign_b = rs2_signed && opb[63];
        mag_a  = sign_a ? (64'd0 - opa) : opa;
        mag_b  = sign_b ? (64'd0 - opb) : opb;
    end

    // ------------------------------------------------------------------
    // One radix-2^BITS_PER_CYCLE partial product per BUSY cycle
    // ------------------------------------------------------------------
    logic [127:0] pp;
    logic [127:0] pp_shifted;
    logic [6:0]   shamt;

    always_comb begin
        pp = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_q[i]) begin
                pp = pp + (128'(mcand_q) << i);
            end
        end
        shamt      = 7'(count_q * BITS_PER_CYCLE);
        pp_shifted = pp << shamt;
    end

    // ------------------------------------------------------------------
    // Sign fix-up and result selection (used in FIX)
    // ------------------------------------------------------------------
    logic [127:0] prod;
    logic [63:0]  result;

    always_comb begin
        prod = neg_q ? (128'd0 - acc_q) : acc_q;
        case (op_q)
            OP_MUL:                       result = prod[63:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod[127:64];
            OP_MULW:                      result = {{32{prod[31]}}, prod[31:0]};
            default:                      result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        neg_d      = neg_q;
        op_d       = op_q;
        dst_d      = dst_q;
        pc_d       = pc_q;
        out_data_d = out_data_q;

        if (flush) begin
            state_d = S_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                S_BUSY: begin
                    acc_d    = acc_q + pp_shifted;
                    mplier_d = mplier_q >> BITS_PER_CYCLE;
                    if (count_q == CNT_W'(N - 1)) begin
                        state_d = S_FIX;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                S_FIX: begin
                    out_data_d = result;
                    state_d    = S_DONE;
                end
                S_DONE: begin
                    if (!accept && out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: ;
            endcase

            // Accept is only possible in IDLE, or in DONE with out_ready.
            if (accept) begin
                state_d  = S_BUSY;
                count_d  = '0;
                acc_d    = '0;
                mcand_d  = mag_a;
                mplier_d = mag_b;
                neg_d    = sign_a ^ sign_b;
                op_d     = in_op;
                dst_d    = in_dst;
                pc_d     = in_pc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            neg_q      <= 1'b0;
            op_q       <= '0;
            dst_q      <= '0;
            pc_q       <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            neg_q      <= neg_d;
            op_q       <= op_d;
            dst_q      <= dst_d;
            pc_q       <= pc_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_mult_unit.sv
module tb_mult_unit;

    localparam int unsigned BPC    = 4;
    localparam int          N      = 64 / BPC;
    localparam int unsigned PREG_W = 7;
    localparam int unsigned PC_W   = 64;

    logic                     clk = 1'b0;
    logic                     resetn;
    logic                     in_valid;
    logic [63:0]              in_d1;
    logic [63:0]              in_d2;
    logic [PREG_W-1:0]        in_dst;
    logic [PC_W-1:0]          in_pc;
    logic [PC_W+PREG_W+128:0] in_data;
    logic [2:0]               in_op;
    logic                     in_ready;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [63:0]              out_data;
    logic [PREG_W-1:0]        out_dst;
    logic [PC_W-1:0]          out_pc;

    assign in_data = {in_valid, in_pc, in_dst, in_d2, in_d1};

    always #5 clk = ~clk;

    mult_unit #(
        .BITS_PER_CYCLE(BPC),
        .PREG_W        (PREG_W),
        .PC_W          (PC_W)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_data  (in_data),
        .in_op    (in_op),
        .in_ready (in_ready),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_dst  (out_dst),
        .out_pc   (out_pc)
    );

    typedef struct packed {
        logic [63:0]       data;
        logic [PREG_W-1:0] dst;
        logic [PC_W-1:0]   pc;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected result per output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (resetn && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got data %h dst %h, expected no result",
                         out_data, out_dst);
            end else begin
                e = sb.pop_front();
                chk("result_data", out_data, e.data);
                chk("result_dst", 64'(out_dst), 64'(e.dst));
                chk("result_pc", out_pc, e.pc);
            end
        end
    end

    // Presents an op, waits for in_ready, returns at posedge+1 after accept.
    task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [PREG_W-1:0] dst, input logic [PC_W-1:0] pc,
                        input logic [63:0] res, input bit track);
        bit ok;
        in_op    = op;
        in_d1    = a;
        in_d2    = b;
        in_dst   = dst;
        in_pc    = pc;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout_in_ready", 64'(in_ready), 64'd1);
        if (track) sb.push_back('{data: res, dst: dst, pc: pc});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts rising edges until out_valid is seen; -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("drain_timeout_pending", 64'(sb.size()), 64'd0);
    endtask

    task automatic watch_no_valid(input string name, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk(name, 64'(seen), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_d1     = '0;
        in_d2     = '0;
        in_dst    = '0;
        in_pc     = '0;
        in_op     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", out_data, 64'd0);
        chk("reset_out_dst", 64'(out_dst), 64'd0);
        chk("reset_out_pc", out_pc, 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // MUL 3 * -5 with latency check
        send(3'b000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 7'h15, 64'h1000,
             64'hFFFF_FFFF_FFFF_FFF1, 1'b1);
        wait_valid(lat);
        chk("mul_latency", 64'(lat), 64'(N + 1));

        // Directed vectors, issued back to back with out_ready high
        vecs.push_back('{3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE});
        vecs.push_back('{3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
        vecs.push_back('{3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{3'b100, 64'h0000_0000_7FFF_FFFF, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFE});
        vecs.push_back('{3'b100, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002, 64'hFFFF_FFFF_FFFF_FFFE});
        vecs.push_back('{3'b100, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'h1});
        vecs.push_back('{3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000});
        vecs.push_back('{3'b001, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
        vecs.push_back('{3'b001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000});
        vecs.push_back('{3'b011, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000});
        vecs.push_back('{3'b010, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000});
        vecs.push_back('{3'b000, 64'h0000_0000_1234_5678, 64'h1000,               64'h0000_0123_4567_8000});
        vecs.push_back('{3'b000, 64'h0,                   64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
        vecs.push_back('{3'b101, 64'd5,                   64'd7,                  64'h0});
        vecs.push_back('{3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, PREG_W'(i + 1), 64'h2000 + 64'(i * 4),
                 vecs[i].res, 1'b1);
        end
        drain();

        // Back-pressure: hold result for 5 cycles, then accept next op as it is taken
        out_ready = 1'b0;
        send(3'b000, 64'd6, 64'd7, 7'h2A, 64'h3000, 64'd42, 1'b1);
        wait_valid(lat);
        chk("bp_latency", 64'(lat), 64'(N + 1));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_data", out_data, 64'd42);
            chk("bp_out_dst", 64'(out_dst), 64'h2A);
            chk("bp_out_pc", out_pc, 64'h3000);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        in_op     = 3'b011;
        in_d1     = 64'hFFFF_FFFF_FFFF_FFFF;
        in_d2     = 64'd4;
        in_dst    = 7'h2B;
        in_pc     = 64'h3004;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        sb.push_back('{data: 64'd3, dst: 7'h2B, pc: 64'h3004});
        @(negedge clk);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(lat);
        chk("bp_second_latency", 64'(lat), 64'(N + 1));
        drain();

        // Flush at BUSY count 7
        send(3'b000, 64'd100, 64'd200, 7'h05, 64'h5000, 64'd0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy_in_ready", 64'(in_ready), 64'd1);
        watch_no_valid("flush_busy_no_valid", N + 6);

        // Input presented in the flush cycle is not accepted
        in_op    = 3'b000;
        in_d1    = 64'd9;
        in_d2    = 64'd9;
        in_dst   = 7'h06;
        in_pc    = 64'h5004;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        watch_no_valid("flush_input_ignored", N + 6);

        // Flush in DONE
        out_ready = 1'b0;
        send(3'b000, 64'd11, 64'd13, 7'h07, 64'h6000, 64'd0, 1'b0);
        wait_valid(lat);
        chk("flush_done_reached", 64'(out_valid), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_done_out_valid", 64'(out_valid), 64'd0);
        chk("flush_done_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        watch_no_valid("flush_done_no_valid", 4);

        // Asynchronous reset mid-BUSY (out_data still holds 143 from the flushed op)
        send(3'b000, 64'h1111, 64'h2222, 7'h33, 64'h4444, 64'd0, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("areset_out_valid", 64'(out_valid), 64'd0);
        chk("areset_out_data", out_data, 64'd0);
        chk("areset_out_dst", 64'(out_dst), 64'd0);
        chk("areset_out_pc", out_pc, 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        send(3'b000, 64'd5, 64'd7, 7'h11, 64'h7000, 64'd35, 1'b1);
        wait_valid(lat);
        chk("areset_mul_latency", 64'(lat), 64'(N + 1));
        drain();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
